// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file bus: write, dual read, issue scoreboard and clear handshake
interface regfile_mp_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             clear_req;
    logic             reg_write;
    logic [AW-1:0]    write_register;
    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    read_register1;
    logic [AW-1:0]    read_register2;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;
    logic             issue_valid;
    logic [AW-1:0]    issue_register;
    logic             busy1;
    logic             busy2;
    logic             ready;

    modport master (
        output clear_req, reg_write, write_register, write_data,
        output read_register1, read_register2, issue_valid, issue_register,
        input  read_data1, read_data2, busy1, busy2, ready
    );

    modport slave (
        input  clear_req, reg_write, write_register, write_data,
        input  read_register1, read_register2, issue_valid, issue_register,
        output read_data1, read_data2, busy1, busy2, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-read register file with pending scoreboard and walking clear; optional macro REGFILE_MP_BYPASS_EN
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    regfile_mp_if.slave bus
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [AW-1:0]    clr_idx;
    logic [AW-1:0]    clr_idx_nx;
    logic [WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0] pending;

    logic             in_ready;
    logic             clear_go;
    logic             wr_en;
    logic             iss_en;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             bz1;
    logic             bz2;

    // Accept writes/issues only in READY, and drop them in the cycle that starts a clear
    assign in_ready = (state == ST_READY);
    assign clear_go = in_ready && bus.clear_req;
    assign wr_en    = in_ready && !reset && !bus.clear_req && bus.reg_write
                      && (bus.write_register != '0);
    assign iss_en   = in_ready && !reset && !bus.clear_req && bus.issue_valid
                      && (bus.issue_register != '0);

    // State register; reset restarts the clear walk from register 1
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= FIRST_IDX;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // Next state: READY waits for clear_req, CLEAR walks indices 1..DEPTH-1
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        case (state)
            ST_READY: begin
                if (bus.clear_req) begin
                    state_nx   = ST_CLEAR;
                    clr_idx_nx = FIRST_IDX;
                end
            end
            ST_CLEAR: begin
                clr_idx_nx = clr_idx + FIRST_IDX;
                if (clr_idx == LAST_IDX) begin
                    state_nx = ST_READY;
                end
            end
            default: begin
                state_nx   = ST_CLEAR;
                clr_idx_nx = FIRST_IDX;
            end
        endcase
    end

    // Register array: one entry zeroed per CLEAR cycle, otherwise accepted writes; r0 never written
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            rf[clr_idx] <= '0;
        end else if (wr_en) begin
            rf[bus.write_register] <= bus.write_data;
        end
    end

    // Scoreboard: flushed on reset or clear entry; a same-cycle issue overrides the write's clear
    always_ff @(posedge clk) begin
        if (reset || clear_go) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[bus.write_register] <= 1'b0;
            end
            if (iss_en) begin
                pending[bus.issue_register] <= 1'b1;
            end
        end
    end

    // Combinational read ports; everything reads 0 and not busy while clearing
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        bz1 = 1'b0;
        bz2 = 1'b0;
        if (in_ready) begin
            if (bus.read_register1 != '0) rd1 = rf[bus.read_register1];
            if (bus.read_register2 != '0) rd2 = rf[bus.read_register2];
            bz1 = pending[bus.read_register1];
            bz2 = pending[bus.read_register2];
`ifdef REGFILE_MP_BYPASS_EN
            if (bus.reg_write && (bus.write_register != '0)) begin
                if (bus.write_register == bus.read_register1) begin
                    rd1 = bus.write_data;
                    bz1 = bus.issue_valid && (bus.issue_register == bus.read_register1);
                end
                if (bus.write_register == bus.read_register2) begin
                    rd2 = bus.write_data;
                    bz2 = bus.issue_valid && (bus.issue_register == bus.read_register2);
                end
            end
`endif
        end
    end

    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.busy1      = bz1;
    assign bus.busy2      = bz2;
    assign bus.ready      = in_ready;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp: vector table, corner sequences, random vs model
module tb_regfile_mp;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic          clr;
        logic          we;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic          iv;
        logic [AW-1:0] ia;
        logic [31:0]   e1;
        logic [31:0]   e2;
        logic          eb1;
        logic          eb2;
        logic          erdy;
    } vec_t;

    vec_t tbl[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: clearing is a countdown, registers are wiped at clear entry
    logic [31:0] mm [DEPTH];
    logic        pp [DEPTH];
    int          clr_left = 0;

    logic [66:0] o_b;
    logic [66:0] e_b;

    function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
        if (clr_left != 0 || a == 0) return 32'h0;
`ifdef REGFILE_MP_BYPASS_EN
        if (bus.reg_write && bus.write_register != 0 && bus.write_register == a) return bus.write_data;
`endif
        return mm[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        if (clr_left != 0) return 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        if (bus.reg_write && bus.write_register != 0 && bus.write_register == a)
            return bus.issue_valid && bus.issue_register == a;
`endif
        return pp[a];
    endfunction

    task automatic m_wipe();
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = 32'h0;
            pp[i] = 1'b0;
        end
        clr_left = DEPTH - 1;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_wipe();
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (bus.clear_req) begin
            m_wipe();
        end else begin
            if (bus.reg_write && bus.write_register != 0) begin
                mm[bus.write_register] = bus.write_data;
                pp[bus.write_register] = 1'b0;
            end
            if (bus.issue_valid && bus.issue_register != 0) pp[bus.issue_register] = 1'b1;
        end
    endtask

    task automatic drive(input logic rst, input logic clr, input logic we, input logic [AW-1:0] wa,
                         input logic [31:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic iv, input logic [AW-1:0] ia);
        reset              = rst;
        bus.clear_req      = clr;
        bus.reg_write      = we;
        bus.write_register = wa;
        bus.write_data     = wd;
        bus.read_register1 = r1;
        bus.read_register2 = r2;
        bus.issue_valid    = iv;
        bus.issue_register = ia;
    endtask

    function automatic logic [66:0] outs();
        return {bus.ready, bus.busy1, bus.busy2, bus.read_data1, bus.read_data2};
    endfunction

    // Drive one cycle, capture outputs and model expectation before the edge, then clock it
    task automatic step(input logic rst, input logic clr, input logic we, input logic [AW-1:0] wa,
                        input logic [31:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic iv, input logic [AW-1:0] ia);
        drive(rst, clr, we, wa, wd, r1, r2, iv, ia);
        #2;
        o_b = outs();
        e_b = {clr_left == 0, m_busy(r1), m_busy(r2), m_rd(r1), m_rd(r2)};
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%0b b1=%0b b2=%0b rd1=%h rd2=%h, want rdy=%0b b1=%0b b2=%0b rd1=%h rd2=%h",
                     nm, act[66], act[65], act[64], act[63:32], act[31:0],
                     exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Count edges until ready; optionally hammer the block with inputs that must be ignored
    task automatic wait_ready(input logic noise, output int cnt, output int quiet);
        cnt   = 0;
        quiet = 1;
        while (cnt < 100) begin
            if (noise) drive(0, 1, 1, 5'd9, 32'hdead, 5'd9, 5'd1, 1, 5'd9);
            else       drive(0, 0, 0, 5'd0, 32'h0, 5'd1, 5'd5, 0, 5'd0);
            #1;
            if (bus.ready) break;
            if (bus.read_data1 != 0 || bus.read_data2 != 0 || bus.busy1 || bus.busy2) quiet = 0;
            @(posedge clk);
            model_edge();
            #1;
            cnt++;
        end
        drive(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int quiet;
        logic [66:0] exp_b;

        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = 32'h0;
            pp[i] = 1'b0;
        end
        drive(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset for one cycle, then the walk takes DEPTH-1 edges
        step(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        drive(0, 0, 0, 5'd0, 32'h0, 5'd1, 5'd2, 0, 5'd0);
        #1;
        chk("reset_state", outs(), 67'h0);
        wait_ready(0, cnt, quiet);
        chk_int("reset_walk_len", cnt, 31);
        chk_int("reset_walk_quiet", quiet, 1);

        //                clr we wa     wd          r1     r2     iv ia     e1          e2          b1 b2 rdy
        tbl.push_back('{1'b0, 1'b1, 5'd1, 32'h5,    5'd2, 5'd3, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd2, 32'h6,    5'd1, 5'd3, 1'b0, 5'd0, 32'h5,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd1, 5'd2, 1'b0, 5'd0, 32'h5,    32'h6,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd1, 32'h8,    5'd2, 5'd3, 1'b0, 5'd0, 32'h6,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd1, 5'd0, 1'b0, 5'd0, 32'h8,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd0, 32'h8,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd0, 5'd1, 1'b0, 5'd0, 32'h0,    32'h8,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd3, 5'd0, 1'b1, 5'd3, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd3, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd3, 32'h1234, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd3, 5'd3, 1'b1, 5'd5, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 5'd4, 32'h1234, 5'd3, 5'd2, 1'b1, 5'd4, 32'h1234, 32'h6,    1'b0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0,    5'd4, 5'd5, 1'b0, 5'd0, 32'h1234, 32'h0,    1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 5'd6, 32'h77,   5'd1, 5'd5, 1'b1, 5'd7, 32'h8,    32'h0,    1'b0, 1'b1, 1'b1});

        foreach (tbl[i]) begin
            step(0, tbl[i].clr, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2, tbl[i].iv, tbl[i].ia);
            chk($sformatf("tbl%0d", i), o_b, {tbl[i].erdy, tbl[i].eb1, tbl[i].eb2, tbl[i].e1, tbl[i].e2});
        end

        // The last table row requested a clear; ignored traffic during the walk must leave no trace
        wait_ready(1, cnt, quiet);
        chk_int("clear_walk_len", cnt, 31);
        chk_int("clear_walk_quiet", quiet, 1);
        step(0, 0, 0, 5'd0, 32'h0, 5'd1, 5'd5, 0, 5'd0);
        chk("after_clear_r1_r5", o_b, {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        step(0, 0, 0, 5'd0, 32'h0, 5'd6, 5'd9, 0, 5'd0);
        chk("after_clear_r6_r9", o_b, {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});
        step(0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd4, 0, 5'd0);
        chk("after_clear_r7_r4", o_b, {1'b1, 1'b0, 1'b0, 32'h0, 32'h0});

        // Write-to-read forwarding corner
        step(0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 5'd7);
        step(0, 0, 1, 5'd7, 32'hA5, 5'd7, 5'd7, 0, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
        exp_b = {1'b1, 1'b0, 1'b0, 32'hA5, 32'hA5};
`else
        exp_b = {1'b1, 1'b1, 1'b1, 32'h0, 32'h0};
`endif
        chk("bypass_same_cycle", o_b, exp_b);
        step(0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0);
        chk("bypass_after_edge", o_b, {1'b1, 1'b0, 1'b0, 32'hA5, 32'hA5});
        step(0, 0, 1, 5'd7, 32'h5A, 5'd7, 5'd0, 1, 5'd7);
`ifdef REGFILE_MP_BYPASS_EN
        exp_b = {1'b1, 1'b1, 1'b0, 32'h5A, 32'h0};
`else
        exp_b = {1'b1, 1'b0, 1'b0, 32'hA5, 32'h0};
`endif
        chk("bypass_wr_issue", o_b, exp_b);
        step(0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 5'd0);
        chk("wr_issue_after", o_b, {1'b1, 1'b1, 1'b0, 32'h5A, 32'h0});

        // Reset ten cycles into a clear restarts the full walk
        step(0, 1, 0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 5'd0);
        repeat (10) step(0, 0, 0, 5'd0, 32'h0, 5'd7, 5'd0, 0, 5'd0);
        chk("mid_clear_state", o_b, 67'h0);
        step(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0);
        wait_ready(0, cnt, quiet);
        chk_int("restart_walk_len", cnt, 31);
        chk_int("restart_walk_quiet", quiet, 1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic          rr, cc, ww, ii;
            logic [AW-1:0] wa, r1, r2, ia;
            rr = ($urandom_range(0, 299) == 0);
            cc = ($urandom_range(0, 59) == 0);
            ww = $urandom_range(0, 1) == 1;
            ii = $urandom_range(0, 2) == 0;
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            r1 = AW'($urandom_range(0, 7));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom_range(0, 7));
            ia = AW'($urandom_range(0, 7));
            step(rr, cc, ww, wa, $urandom, r1, r2, ii, ia);
            chk($sformatf("rand%0d", n), o_b, e_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
